uart_matrix_loader: RTL
=======================

Name: uart_matrix_loader

Overview:
- Downstream consumer of the UART byte receiver (8-bit d_out plus rx_status strobe).
- Parses a framed byte stream into N×N matrix elements and writes them into operand buffer A or B.
- Signals the tiled multiply core to start once both operands are loaded.
- Includes an inter-byte timeout and frame-error reporting.

Parameters:
- N, 4, matrix dimension; N*N elements per frame.
- ELEM_BYTES, 2, bytes per element, little-endian; element width is 8*ELEM_BYTES.
- ADDR_W, 4, element address width; N*N must not exceed 2^ADDR_W.
- TIMEOUT, 4096, clk cycles allowed between bytes inside a frame.
- HDR, 8'hA5, frame header byte.

Ports:
- clk  in  1  system clock (same clock as the receiver).
- reset  in  1  asynchronous, active-high.
- rx_byte  in  8  receiver parallel data.
- rx_status  in  1  receiver data-available level/strobe.
- core_busy  in  1  multiply core running; new frames are refused while high.
- wr_en  out  1  one-cycle element write strobe.
- wr_sel  out  1  write target: 0 = A buffer, 1 = B buffer.
- wr_addr  out  ADDR_W  element index, row-major, 0..N*N-1.
- wr_data  out  8*ELEM_BYTES  assembled element.
- a_loaded  out  1  A buffer holds a complete matrix.
- b_loaded  out  1  B buffer holds a complete matrix.
- start  out  1  one-cycle pulse to the core.
- frame_err  out  1  sticky error flag; cleared by the next accepted header.

Behaviour:
- Reset (async): every output is 0; FSM in IDLE; all counters, the assembly register and the rx_status history flop are 0.
- Byte acceptance:
  - rx_status is registered into rx_q.
  - A byte is accepted on a clock edge where rx_status=1 and rx_q=0, using rx_byte sampled at that same edge.
  - rx_status held high for several cycles counts as exactly one byte.
- FSM states: IDLE, CMD, DATA, DONE.
- IDLE:
  - Accepted byte == HDR with core_busy=0: clear frame_err, go to CMD.
  - Any other byte, or HDR while core_busy=1: ignored; stay in IDLE.
- CMD:
  - 8'h01: target = A; clear a_loaded; go to DATA.
  - 8'h02: target = B; clear b_loaded; go to DATA.
  - Any other value: set frame_err; go to IDLE.
  - Element count and byte count reset to 0 on entry to DATA.
- DATA:
  - Each accepted byte goes into byte lane byte_cnt of the assembly register (lane 0 = bits 7:0).
  - When the lane ELEM_BYTES-1 byte is accepted at edge t, the cycle after edge t has wr_en=1, wr_addr=elem_cnt, wr_sel=target, wr_data=full element. The wr_* outputs are registered.
  - byte_cnt then wraps to 0 and elem_cnt increments.
  - After element N*N-1 is written, go to DONE.
- DONE (one cycle):
  - Set the target's loaded flag.
  - If both flags are 1 after this update, start=1 for the next cycle and both flags clear in that same cycle.
  - Go to IDLE.
- Timeout:
  - The counter clears on every accepted byte and on entering CMD; it increments in CMD and DATA only.
  - When it reaches TIMEOUT-1: set frame_err; go to IDLE.
  - Partial writes are not undone; the target's loaded flag stays 0.
- core_busy has no effect on a frame already past IDLE.
- Simultaneous events:
  - A byte accepted on the same edge the timeout terminal count is reached: the byte wins and the counter clears.
  - A write strobe and start are never asserted in the same cycle.
- Reset mid-frame: immediate return to IDLE; flags clear; no write strobe issued.
- wr_data and wr_addr hold their last values when wr_en=0.

Test Plan:
- Reset, then idle with no bytes → all outputs 0; bytes 8'h00 and 8'h5A are ignored and no write occurs.
- Send A5 01 followed by 32 bytes 00 00, 01 00 … 0F 00 → 16 strobes with wr_sel=0, wr_addr 0..15, wr_data 16'h0000..16'h000F; then a_loaded=1, start=0.
- Continue with A5 02 plus 32 bytes 34 12 repeated → 16 strobes with wr_sel=1, wr_data=16'h1234; one-cycle start pulse; a_loaded and b_loaded both return to 0.
- Send A5 07 → frame_err=1, no writes, FSM back in IDLE; a following A5 clears frame_err.
- Send A5 01 then 5 data bytes, then silence for 4096 cycles → 2 strobes only (addr 0,1), frame_err=1, a_loaded=0; hold rx_status high 10 cycles per byte in a retry frame → each byte counted once.
- Assert reset after 7 data bytes → outputs 0 immediately; HDR with core_busy=1 → ignored; full frame after core_busy falls → loads normally.

Source files
------------

// File: rtl/uart_matrix_loader.sv
// rtl/uart_matrix_loader.sv - framed UART byte stream to matrix operand buffer loader
module uart_matrix_loader #(
    parameter int         N          = 4,
    parameter int         ELEM_BYTES = 2,
    parameter int         ADDR_W     = 4,
    parameter int         TIMEOUT    = 4096,
    parameter logic [7:0] HDR        = 8'hA5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              rx_byte,
    input  logic                    rx_status,
    input  logic                    core_busy,
    output logic                    wr_en,
    output logic                    wr_sel,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [8*ELEM_BYTES-1:0] wr_data,
    output logic                    a_loaded,
    output logic                    b_loaded,
    output logic                    start,
    output logic                    frame_err
);

    localparam int EW   = 8 * ELEM_BYTES;
    localparam int BC_W = (ELEM_BYTES > 1) ? $clog2(ELEM_BYTES) : 1;
    localparam int TC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(ELEM_BYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_ELEM = ADDR_W'(N * N - 1);
    localparam logic [TC_W-1:0]   TMO_MAX   = TC_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    state_t            state_q, state_d;
    logic              rx_q;
    logic              accept;
    logic              target_q, target_d;
    logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0] elem_cnt_q, elem_cnt_d;
    logic [EW-1:0]     asm_q, asm_d, merged;
    logic [TC_W-1:0]   tmo_q, tmo_d;
    logic              wr_en_d, wr_sel_d, a_d, b_d, start_d, err_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [EW-1:0]     wr_data_d;
    logic              a_next, b_next;

    // A byte is taken only on the rising edge of rx_status so a held level counts once.
    assign accept = rx_status & ~rx_q;

    // Frame parser: next state, counters, write strobe and flag updates.
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        byte_cnt_d = byte_cnt_q;
        elem_cnt_d = elem_cnt_q;
        asm_d      = asm_q;
        tmo_d      = tmo_q;
        wr_en_d    = 1'b0;
        wr_sel_d   = wr_sel;
        wr_addr_d  = wr_addr;
        wr_data_d  = wr_data;
        a_d        = a_loaded;
        b_d        = b_loaded;
        start_d    = 1'b0;
        err_d      = frame_err;
        a_next     = a_loaded;
        b_next     = b_loaded;
        merged     = asm_q;
        for (int i = 0; i < ELEM_BYTES; i++) begin
            if (byte_cnt_q == BC_W'(i)) begin
                merged[i*8 +: 8] = rx_byte;
            end
        end

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (accept && rx_byte == HDR && !core_busy) begin
                    err_d   = 1'b0;
                    state_d = CMD;
                end
            end
            CMD: begin
                if (accept) begin
                    tmo_d      = '0;
                    byte_cnt_d = '0;
                    elem_cnt_d = '0;
                    if (rx_byte == 8'h01) begin
                        target_d = 1'b0;
                        a_d      = 1'b0;
                        state_d  = DATA;
                    end else if (rx_byte == 8'h02) begin
                        target_d = 1'b1;
                        b_d      = 1'b0;
                        state_d  = DATA;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else if (tmo_q == TMO_MAX) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            DATA: begin
                if (accept) begin
                    tmo_d = '0;
                    asm_d = merged;
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d = '0;
                        elem_cnt_d = elem_cnt_q + 1'b1;
                        wr_en_d    = 1'b1;
                        wr_sel_d   = target_q;
                        wr_addr_d  = elem_cnt_q;
                        wr_data_d  = merged;
                        if (elem_cnt_q == LAST_ELEM) begin
                            state_d = DONE;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end else if (tmo_q == TMO_MAX) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            DONE: begin
                a_next = a_loaded | ~target_q;
                b_next = b_loaded | target_q;
                if (a_next && b_next) begin
                    start_d = 1'b1;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                end else begin
                    a_d = a_next;
                    b_d = b_next;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; async reset returns everything to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rx_q       <= 1'b0;
            target_q   <= 1'b0;
            byte_cnt_q <= '0;
            elem_cnt_q <= '0;
            asm_q      <= '0;
            tmo_q      <= '0;
            wr_en      <= 1'b0;
            wr_sel     <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            a_loaded   <= 1'b0;
            b_loaded   <= 1'b0;
            start      <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_q       <= rx_status;
            target_q   <= target_d;
            byte_cnt_q <= byte_cnt_d;
            elem_cnt_q <= elem_cnt_d;
            asm_q      <= asm_d;
            tmo_q      <= tmo_d;
            wr_en      <= wr_en_d;
            wr_sel     <= wr_sel_d;
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_data_d;
            a_loaded   <= a_d;
            b_loaded   <= b_d;
            start      <= start_d;
            frame_err  <= err_d;
        end
    end

endmodule
